// File: rtl/rm3100_pkg.sv
// rtl/rm3100_pkg.sv - RM3100 register map, sequencer states and SPI command packing
package rm3100_pkg;

    localparam logic [7:0] REG_POLL   = 8'h00;
    localparam logic [7:0] REG_CMM    = 8'h01;
    localparam logic [7:0] REG_CCX    = 8'h04;
    localparam logic [7:0] REG_TMRC   = 8'h0B;
    localparam logic [7:0] REG_MX     = 8'h24;
    localparam logic [7:0] REG_STATUS = 8'h34;

    localparam int STATUS_DRDY_BIT = 7;

    typedef enum logic [2:0] {
        ST_CFG    = 3'd0,
        ST_READY  = 3'd1,
        ST_TRIG   = 3'd2,
        ST_STATUS = 3'd3,
        ST_READ   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    function automatic logic [15:0] pack_cmd(input logic [7:0] data, input logic [7:0] addr);
        return {data, addr};
    endfunction

endpackage

// File: rtl/rm3100_sampler.sv
// rtl/rm3100_sampler.sv - RM3100 configure/trigger/poll/read sequencer driving the spi_rm3100 master
module rm3100_sampler
    import rm3100_pkg::*;
#(
    parameter logic [15:0] CYCLE_COUNT = 16'h0032,
    parameter logic [7:0]  TMRC_VAL    = 8'h92,
    parameter logic [7:0]  CMM_VAL     = 8'h70,
    parameter logic [7:0]  POLL_CMD    = 8'h70,
    parameter int unsigned POLL_MAX    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_req,
    output logic        busy,
    output logic        sample_valid,
    output logic        sample_err,
    output logic [19:0] xdata,
    output logic [19:0] ydata,
    output logic [19:0] zdata,
    output logic        spi_req,
    output logic        spi_wr_en,
    output logic [15:0] spi_data_tx,
    input  logic [7:0]  spi_data_rx,
    input  logic        spi_done
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_e        state;
    logic [2:0]    cfg_idx;
    logic [PW-1:0] poll_cnt;
    logic [3:0]    rd_idx;
    logic          pending;
    logic [71:0]   shadow;
    logic [71:0]   shadow_next;
    logic [15:0]   cfg_cmd;
    logic          done_ok;

    // A done pulse only completes a transaction this block actually launched,
    // so a stale pulse from before a reset can never advance the sequence.
    assign done_ok = pending && spi_done && !spi_req;
    assign busy    = (state != ST_READY);

    always_comb begin
        cfg_cmd = 16'h0000;
        case (cfg_idx)
            3'd0: cfg_cmd = pack_cmd(CYCLE_COUNT[15:8], REG_CCX);
            3'd1: cfg_cmd = pack_cmd(CYCLE_COUNT[7:0],  REG_CCX + 8'd1);
            3'd2: cfg_cmd = pack_cmd(CYCLE_COUNT[15:8], REG_CCX + 8'd2);
            3'd3: cfg_cmd = pack_cmd(CYCLE_COUNT[7:0],  REG_CCX + 8'd3);
            3'd4: cfg_cmd = pack_cmd(CYCLE_COUNT[15:8], REG_CCX + 8'd4);
            3'd5: cfg_cmd = pack_cmd(CYCLE_COUNT[7:0],  REG_CCX + 8'd5);
            3'd6: cfg_cmd = pack_cmd(TMRC_VAL, REG_TMRC);
            3'd7: cfg_cmd = pack_cmd(CMM_VAL,  REG_CMM);
            default: cfg_cmd = 16'h0000;
        endcase
    end

    // Byte 0 (MX2) lands in the top byte so each axis is a contiguous 24-bit field.
    always_comb begin
        shadow_next = shadow;
        shadow_next[{4'd8 - rd_idx, 3'b000} +: 8] = spi_data_rx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_CFG;
            cfg_idx      <= '0;
            poll_cnt     <= '0;
            rd_idx       <= '0;
            pending      <= 1'b0;
            shadow       <= '0;
            spi_req      <= 1'b0;
            spi_wr_en    <= 1'b0;
            spi_data_tx  <= '0;
            sample_valid <= 1'b0;
            sample_err   <= 1'b0;
            xdata        <= '0;
            ydata        <= '0;
            zdata        <= '0;
        end else begin
            spi_req      <= 1'b0;
            sample_valid <= 1'b0;
            sample_err   <= 1'b0;
            case (state)
                ST_CFG: begin
                    if (!pending) begin
                        spi_req     <= 1'b1;
                        pending     <= 1'b1;
                        spi_wr_en   <= 1'b1;
                        spi_data_tx <= cfg_cmd;
                    end else if (done_ok) begin
                        pending <= 1'b0;
                        cfg_idx <= cfg_idx + 3'd1;
                        if (cfg_idx == 3'd7) state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (sample_req) state <= ST_TRIG;
                end
                ST_TRIG: begin
                    if (!pending) begin
                        spi_req     <= 1'b1;
                        pending     <= 1'b1;
                        spi_wr_en   <= 1'b1;
                        spi_data_tx <= pack_cmd(POLL_CMD, REG_POLL);
                    end else if (done_ok) begin
                        pending  <= 1'b0;
                        poll_cnt <= '0;
                        state    <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (!pending) begin
                        spi_req     <= 1'b1;
                        pending     <= 1'b1;
                        spi_wr_en   <= 1'b0;
                        spi_data_tx <= pack_cmd(8'h00, REG_STATUS);
                    end else if (done_ok) begin
                        pending <= 1'b0;
                        if (spi_data_rx[STATUS_DRDY_BIT]) begin
                            rd_idx <= '0;
                            state  <= ST_READ;
                        end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                            sample_err <= 1'b1;
                            state      <= ST_READY;
                        end else begin
                            poll_cnt <= poll_cnt + PW'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (!pending) begin
                        spi_req     <= 1'b1;
                        pending     <= 1'b1;
                        spi_wr_en   <= 1'b0;
                        spi_data_tx <= pack_cmd(8'h00, REG_MX + {4'd0, rd_idx});
                    end else if (done_ok) begin
                        pending <= 1'b0;
                        shadow  <= shadow_next;
                        rd_idx  <= rd_idx + 4'd1;
                        // Publish straight from the merged shadow so valid follows the last byte by one cycle.
                        if (rd_idx == 4'd8) begin
                            xdata        <= shadow_next[71:52];
                            ydata        <= shadow_next[47:28];
                            zdata        <= shadow_next[23:4];
                            sample_valid <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_READY;
                default: state <= ST_CFG;
            endcase
        end
    end

endmodule
